// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one word from instruction memory, presents
// it to decode, and keeps it there until decode consumes it. A redirect
// restarts fetching at a new target.
// Optional build macro: IFU_MISALIGN_TRAP_EN. When it is defined, a redirect
// to a target that is not word-aligned traps into a sticky ERROR state. When
// it is undefined, the low two bits of the target are cleared instead.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic        misaligned_err
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
`ifdef IFU_MISALIGN_TRAP_EN
  localparam logic [1:0] ST_ERROR = 2'd2;
`endif

  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] instruction_r;
  logic [31:0] instr_pc_r;
  logic        instr_valid_r;
  logic [31:0] instr_count_r;
  logic        misaligned_err_r;

  logic [1:0]  state_n_s;
  logic [31:0] pc_n_s;
  logic [31:0] instruction_n_s;
  logic [31:0] instr_pc_n_s;
  logic        instr_valid_n_s;
  logic [31:0] instr_count_n_s;
  logic        misaligned_err_n_s;
  logic        redirect_take_s;
  logic [31:0] redirect_tgt_s;

  // Decide whether a redirect is honoured this cycle and where it goes.
  always_comb begin
    redirect_take_s = 1'b0;
    redirect_tgt_s  = 32'h0000_0000;
`ifdef IFU_MISALIGN_TRAP_EN
    redirect_tgt_s  = redirect_pc;
    if (redirect_valid && (state_r != ST_ERROR)) begin
      redirect_take_s = 1'b1;
    end else begin
      redirect_take_s = 1'b0;
    end
`else
    // Word alignment is forced, so the low target bits are simply dropped.
    redirect_tgt_s  = redirect_pc & 32'hFFFF_FFFC;
    redirect_take_s = redirect_valid;
`endif
  end

  // Next-state and next-datapath values; a redirect beats memory and decode.
  always_comb begin
    state_n_s          = state_r;
    pc_n_s             = pc_r;
    instruction_n_s    = instruction_r;
    instr_pc_n_s       = instr_pc_r;
    instr_valid_n_s    = instr_valid_r;
    instr_count_n_s    = instr_count_r;
    misaligned_err_n_s = misaligned_err_r;
    if (redirect_take_s) begin
`ifdef IFU_MISALIGN_TRAP_EN
      if (redirect_tgt_s[1:0] != 2'b00) begin
        state_n_s          = ST_ERROR;
        misaligned_err_n_s = 1'b1;
        instr_valid_n_s    = 1'b0;
      end else begin
        state_n_s       = ST_FETCH;
        pc_n_s          = redirect_tgt_s;
        instr_valid_n_s = 1'b0;
      end
`else
      state_n_s       = ST_FETCH;
      pc_n_s          = redirect_tgt_s;
      instr_valid_n_s = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_ready) begin
            instruction_n_s = imem_rdata;
            instr_pc_n_s    = pc_r;
            pc_n_s          = pc_r + 32'd4;
            instr_valid_n_s = 1'b1;
            state_n_s       = ST_ISSUE;
          end else begin
            state_n_s = ST_FETCH;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            instr_count_n_s = instr_count_r + 32'd1;
            instr_valid_n_s = 1'b0;
            state_n_s       = ST_FETCH;
          end else begin
            state_n_s = ST_ISSUE;
          end
        end
`ifdef IFU_MISALIGN_TRAP_EN
        ST_ERROR: begin
          // Only reset leaves the trap.
          state_n_s = ST_ERROR;
        end
`endif
        default: begin
          state_n_s       = ST_FETCH;
          instr_valid_n_s = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_FETCH;
      pc_r             <= RESET_PC;
      instruction_r    <= 32'h0000_0000;
      instr_pc_r       <= 32'h0000_0000;
      instr_valid_r    <= 1'b0;
      instr_count_r    <= 32'h0000_0000;
      misaligned_err_r <= 1'b0;
    end else begin
      state_r          <= state_n_s;
      pc_r             <= pc_n_s;
      instruction_r    <= instruction_n_s;
      instr_pc_r       <= instr_pc_n_s;
      instr_valid_r    <= instr_valid_n_s;
      instr_count_r    <= instr_count_n_s;
      misaligned_err_r <= misaligned_err_n_s;
    end
  end

  // Memory request follows the FETCH state but is held off while in reset.
  always_comb begin
    if (reset) begin
      imem_req = 1'b0;
    end else if (state_r == ST_FETCH) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
  end

  assign imem_addr   = pc_r;
  assign instr_valid = instr_valid_r;
  assign instruction = instruction_r;
  assign instr_pc    = instr_pc_r;
  assign pc_plus4    = instr_pc_r + 32'd4;
  assign instr_count = instr_count_r;
`ifdef IFU_MISALIGN_TRAP_EN
  assign misaligned_err = misaligned_err_r;
`else
  assign misaligned_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit in its default build.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_count;
  logic        misaligned_err;

  int checks;
  int failures;

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instruction(instruction),
    .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .instr_count(instr_count), .misaligned_err(misaligned_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: "is a word being presented", where fetching
  // resumes, what was presented, and how many words decode has taken.
  logic        m_armed;
  logic        m_presenting;
  logic [31:0] m_next_fetch;
  logic [31:0] m_word;
  logic [31:0] m_word_addr;
  logic [31:0] m_taken;

  initial m_armed = 1'b0;

  // Model update on every rising edge from the inputs applied that cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_armed      <= 1'b1;
      m_presenting <= 1'b0;
      m_next_fetch <= RPC;
      m_word       <= 32'h0;
      m_word_addr  <= 32'h0;
      m_taken      <= 32'h0;
    end else if (redirect_valid) begin
      m_presenting <= 1'b0;
      m_next_fetch <= {redirect_pc[31:2], 2'b00};
    end else if (!m_presenting && imem_ready) begin
      m_presenting <= 1'b1;
      m_word       <= imem_rdata;
      m_word_addr  <= m_next_fetch;
      m_next_fetch <= m_next_fetch + 32'd4;
    end else if (m_presenting && !stall) begin
      m_presenting <= 1'b0;
      m_taken      <= m_taken + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_compare();
    logic exp_req;
    if (m_armed) begin
      exp_req = !reset && !m_presenting;
      chk("m_imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) chk("m_imem_addr", imem_addr, m_next_fetch);
      chk("m_instr_valid", {31'd0, instr_valid}, {31'd0, m_presenting});
      chk("m_instruction", instruction, m_word);
      chk("m_instr_pc", instr_pc, m_word_addr);
      chk("m_pc_plus4", pc_plus4, m_word_addr + 32'd4);
      chk("m_instr_count", instr_count, m_taken);
      chk("m_misaligned_err", {31'd0, misaligned_err}, 32'd0);
    end
  endtask

  // One clock: apply inputs, let the edge happen, compare at the falling edge.
  task automatic cyc(input logic r, input logic st, input logic rv,
                     input logic [31:0] rpc, input logic rdy, input logic [31:0] rd);
    reset = r; stall = st; redirect_valid = rv; redirect_pc = rpc;
    imem_ready = rdy; imem_rdata = rd;
    @(negedge clk);
    model_compare();
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;

    // Reset with memory answering: the answer is ignored.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_addr", imem_addr, 32'h0000_0100);

    // Back-to-back fetch and consume.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0001);
    chk("s1_valid", {31'd0, instr_valid}, 32'd1);
    chk("s1_ipc", instr_pc, 32'h0000_0100);
    chk("s1_instr", instruction, 32'hA000_0001);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0002);
    chk("s2_addr", imem_addr, 32'h0000_0104);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0003);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0004);
    chk("s4_addr", imem_addr, 32'h0000_0108);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0005);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0006);
    chk("s6_count", instr_count, 32'd3);

    // Redirect to 8, then memory stalls for five cycles.
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wait_addr", imem_addr, 32'h0000_0008);
    chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h012A_4020);
    chk("rdy_instr", instruction, 32'h012A_4020);
    chk("rdy_ipc", instr_pc, 32'h0000_0008);
    chk("rdy_pc4", pc_plus4, 32'h0000_000C);

    // Decode stall holds the word.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    chk("stall_instr", instruction, 32'h012A_4020);
    chk("stall_count", instr_count, 32'd3);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("unstall_count", instr_count, 32'd4);
    chk("unstall_addr", imem_addr, 32'h0000_000C);

    // Redirect in the same cycle as ready: the data is dropped.
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0BAD_0BAD);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h0000_0040);
    chk("redir_instr", instruction, 32'h012A_4020);

    // Redirect in the same cycle as a consume: no count.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
    chk("redir_cons_count", instr_count, 32'd4);
    chk("redir_cons_addr", imem_addr, 32'h0000_0080);

    // Misaligned target is aligned down.
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0042, 1'b0, 32'h0);
    chk("mis_addr", imem_addr, 32'h0000_0040);
    chk("mis_err", {31'd0, misaligned_err}, 32'd0);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_count", instr_count, 32'd5);

    // Reset while decode is stalled.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3333_3333);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4444_4444);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mrst_instr", instruction, 32'h0);
    chk("mrst_ipc", instr_pc, 32'h0);
    chk("mrst_count", instr_count, 32'd0);
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("post_req", {31'd0, imem_req}, 32'd1);
    chk("post_addr", imem_addr, 32'h0000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
